// File: rtl/ram_param.sv
// Single-port parameterised RAM with registered read data, read-before-write,
// out-of-range error pulse and an optional post-reset clear sweep (RAM_PARAM_CLEAR_EN).
module ram_param #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              w,
  input  logic              r,
  input  logic [ADDR_W-1:0] add,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_out,
  output logic              rd_valid,
  output logic              err,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly and nothing wraps.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic in_range_p0;
  logic acc_p0;
  logic wr_p0;
  logic rd_p0;
  logic oor_p0;

  // Stage p0: decode the request presented at this edge
  assign in_range_p0 = ({1'b0, add} < DEPTH_EXT);
  assign acc_p0      = en & ~busy & ~rst & (w | r);
  assign wr_p0       = acc_p0 & w & in_range_p0;
  assign rd_p0       = acc_p0 & r & in_range_p0;
  assign oor_p0      = acc_p0 & ~in_range_p0;

`ifdef RAM_PARAM_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // The sweep must not start until reset has been released.
  assign clr_we = (state == CLEAR) & ~rst;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else if (wr_p0) begin
      mem[add] <= d_in;
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clk) begin
    if (wr_p0) begin
      mem[add] <= d_in;
    end
  end
`endif

  // Stage p1: registered read data, valid and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out    <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_p0;
      err      <= oor_p0;
      if (rd_p0) begin
        d_out <= mem[add];
      end
    end
  end

endmodule

// File: doc/ram_param.md
RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 The block SHALL accept parameter WIDTH, default 16, as the data word width in bits (1..64).
REQ-002 The block SHALL accept parameter ADDR_W, default 9, as the address width in bits (1..16).
REQ-003 The block SHALL accept parameter DEPTH, default 512, as the number of words (1..2^ADDR_W).
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 Port en  input  1  is chip enable; w and r SHALL be ignored while it is low.
REQ-007 Port w  input  1  is the write request.
REQ-008 Port r  input  1  is the read request.
REQ-009 Port add  input  ADDR_W  is the word address.
REQ-010 Port d_in  input  WIDTH  is the write data.
REQ-011 Port d_out  output  WIDTH  is the registered read data.
REQ-012 Port rd_valid  output  1  SHALL pulse high for one cycle when d_out carries new read data.
REQ-013 Port err  output  1  SHALL pulse high for one cycle on an out-of-range access.
REQ-014 Port busy  output  1  SHALL be high while the memory is not accepting accesses.

Function
REQ-015 A write SHALL occur at the clk edge where en=1, w=1, busy=0 and add<DEPTH, storing d_in at mem[add].
REQ-016 A read SHALL be accepted at the clk edge where en=1, r=1, busy=0 and add<DEPTH.
REQ-017 An accepted read SHALL update d_out to mem[add] with exactly 1-cycle latency, with rd_valid=1 in that same cycle.
REQ-018 d_out SHALL hold its last value when no read completes; it SHALL NOT tri-state.
REQ-019 A simultaneous read and write to the same address SHALL be read-before-write: d_out returns the old word and the new word is stored.
REQ-020 An access with add>=DEPTH SHALL leave the memory unchanged, SHALL leave d_out unchanged, SHALL give rd_valid=0, and SHALL assert err=1 in the following cycle.
REQ-021 Accesses presented while busy=1 SHALL be dropped with no err, no rd_valid and no memory change.
REQ-022 Back-to-back reads on consecutive cycles SHALL give rd_valid high on consecutive cycles (full throughput, no bubbles).
REQ-023 Addresses SHALL NOT wrap: add is compared to DEPTH at its full ADDR_W width.

Reset
REQ-024 While rst=1, d_out SHALL be 0, rd_valid SHALL be 0 and err SHALL be 0, independent of clk.
REQ-025 Assertion of rst mid-operation SHALL abort any pending read (no rd_valid afterwards) and any in-progress clear sweep.
REQ-026 Reset SHALL NOT itself alter memory contents, except as defined under Configuration.

Configuration
REQ-027 The macro RAM_PARAM_CLEAR_EN SHALL compile in the post-reset clear sweep.
REQ-028 With RAM_PARAM_CLEAR_EN defined, the FSM SHALL use states IDLE and CLEAR.
REQ-029 With RAM_PARAM_CLEAR_EN defined, rst=1 SHALL force state CLEAR with the sweep pointer at 0 and busy=1.
REQ-030 In CLEAR, each clk edge after rst falls SHALL write 0 to mem[pointer] and increment the pointer.
REQ-031 After the edge that writes mem[DEPTH-1], the FSM SHALL go to IDLE and busy SHALL be 0, giving busy high for exactly DEPTH cycles after reset release.
REQ-032 Without RAM_PARAM_CLEAR_EN, the FSM SHALL be absent, busy SHALL be tied 0, and memory contents after power-up SHALL be undefined.

Verification
REQ-033 Write 16'hA5A5 to add 9'd3, then read add 3 -> d_out=16'hA5A5 with rd_valid=1 exactly one cycle after the read edge.
REQ-034 Hold w=1 and r=1 at add 7, which holds 16'h1111, with d_in=16'h2222 -> d_out=16'h1111; a second read returns 16'h2222.
REQ-035 Use DEPTH=300 and write to add 9'd300 -> err=1 for one cycle, rd_valid=0, and a later read of add 44 (300 mod 256) is unchanged.
REQ-036 With the macro defined, release rst -> busy=1 for 512 cycles; a write issued during the sweep is dropped; reads of add 0 and add 511 after busy falls return 0.
REQ-037 Issue reads to add 1,2,3 on consecutive cycles, then assert rst during the third -> rd_valid is high for the first two only, and d_out=0 while rst=1.
REQ-038 Hold en=0 with w=1 and d_in=16'hFFFF at add 5 -> a subsequent read of add 5 returns the prior value.
